// File: rtl/j_chunk_streamer.sv
// Streams the J matrix from memory as NUM_J_CHUNKS column-chunks into a small
// credit-controlled FIFO that feeds the MatMul consumer over a valid/ready port.
module j_chunk_streamer #(
   parameter int MEM_BANDWIDTH   = 4096,
   parameter int VECTOR_SIZE     = 256,
   parameter int J_ELEMENT_WIDTH = 4,
   parameter int ADDR_WIDTH      = 16,
   parameter int FIFO_DEPTH      = 4,
   localparam int J_COLS_PER_READ = MEM_BANDWIDTH / (VECTOR_SIZE * J_ELEMENT_WIDTH),
   localparam int NUM_J_CHUNKS    = VECTOR_SIZE / J_COLS_PER_READ,
   localparam int IDX_W           = $clog2(NUM_J_CHUNKS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     start,
   input  logic                     abort,
   input  logic [ADDR_WIDTH-1:0]    base_addr,
   output logic                     busy,
   output logic                     done,
   output logic                     mem_req,
   output logic [ADDR_WIDTH-1:0]    mem_addr,
   input  logic                     mem_rvalid,
   input  logic [MEM_BANDWIDTH-1:0] mem_rdata,
   output logic                     chunk_valid,
   input  logic                     chunk_ready,
   output logic [MEM_BANDWIDTH-1:0] chunk_data,
   output logic [IDX_W-1:0]         chunk_idx,
   output logic                     chunk_last,
   output logic [1:0]               dbg_state
);

   localparam int CNT_W = $clog2(NUM_J_CHUNKS + 1);
   localparam int OCC_W = $clog2(FIFO_DEPTH + 1);
   localparam int CRD_W = OCC_W + 1;
   localparam int PTR_W = $clog2(FIFO_DEPTH);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_FETCH = 2'd1,
      S_DRAIN = 2'd2,
      S_FLUSH = 2'd3
   } state_t;

   state_t                  state_q;
   logic                    done_q;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [CNT_W-1:0]        req_cnt_q;
   logic [IDX_W-1:0]        idx_q;
   logic [OCC_W-1:0]        outst_q;
   logic [OCC_W-1:0]        outst_d;
   logic [OCC_W-1:0]        fifo_cnt_q;
   logic [PTR_W-1:0]        wr_ptr_q;
   logic [PTR_W-1:0]        rd_ptr_q;
   logic [MEM_BANDWIDTH-1:0] fifo_mem [FIFO_DEPTH];

   logic             active;
   logic             abort_run;
   logic             rsp_ok;
   logic             push;
   logic             pop;
   logic [CRD_W-1:0] credit_used;

   // Consumer port: a chunk moves on every cycle with chunk_valid & chunk_ready;
   // chunk_valid never depends on chunk_ready and data holds while stalled.
   assign active      = (state_q == S_FETCH) || (state_q == S_DRAIN);
   assign abort_run   = active && abort;
   assign rsp_ok      = mem_rvalid && (outst_q != '0);
   assign chunk_valid = (fifo_cnt_q != '0);
   assign pop         = chunk_valid && chunk_ready && !abort_run;
   assign push        = rsp_ok && active && !abort_run;

   // A pop this cycle frees its slot before any new response can land (latency
   // >= 1), so it may be credited immediately to keep one chunk per cycle.
   assign credit_used = {1'b0, outst_q} + {1'b0, fifo_cnt_q} - {{OCC_W{1'b0}}, pop};

   assign mem_req  = (state_q == S_FETCH) && !abort
                     && (req_cnt_q < CNT_W'(NUM_J_CHUNKS))
                     && (credit_used < CRD_W'(FIFO_DEPTH));
   assign mem_addr = base_q + ADDR_WIDTH'(req_cnt_q);

   assign busy       = (state_q != S_IDLE);
   assign done       = done_q;
   assign chunk_idx  = idx_q;
   assign chunk_last = chunk_valid && (idx_q == IDX_W'(NUM_J_CHUNKS - 1));
   assign chunk_data = fifo_mem[rd_ptr_q];
   assign dbg_state  = state_q;

   always_comb begin
      outst_d = outst_q;
      if (mem_req && !rsp_ok) begin
         outst_d = outst_q + OCC_W'(1);
      end else if (!mem_req && rsp_ok) begin
         outst_d = outst_q - OCC_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         done_q     <= 1'b0;
         base_q     <= '0;
         req_cnt_q  <= '0;
         idx_q      <= '0;
         outst_q    <= '0;
         fifo_cnt_q <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
      end else begin
         done_q  <= 1'b0;
         outst_q <= outst_d;
         case (state_q)
            S_IDLE: begin
               if (start && !abort) begin
                  state_q    <= S_FETCH;
                  base_q     <= base_addr;
                  req_cnt_q  <= '0;
                  idx_q      <= '0;
                  fifo_cnt_q <= '0;
                  wr_ptr_q   <= '0;
                  rd_ptr_q   <= '0;
               end
            end
            S_FETCH, S_DRAIN: begin
               if (abort) begin
                  fifo_cnt_q <= '0;
                  wr_ptr_q   <= '0;
                  rd_ptr_q   <= '0;
                  state_q    <= (outst_d != '0) ? S_FLUSH : S_IDLE;
               end else begin
                  if (mem_req) begin
                     req_cnt_q <= req_cnt_q + CNT_W'(1);
                  end
                  if (push) begin
                     wr_ptr_q <= wr_ptr_q + PTR_W'(1);
                  end
                  if (pop) begin
                     rd_ptr_q <= rd_ptr_q + PTR_W'(1);
                     idx_q    <= idx_q + IDX_W'(1);
                  end
                  fifo_cnt_q <= fifo_cnt_q + OCC_W'(push) - OCC_W'(pop);
                  if (pop && chunk_last) begin
                     state_q <= S_IDLE;
                     done_q  <= 1'b1;
                  end else if ((state_q == S_FETCH) && mem_req
                               && (req_cnt_q == CNT_W'(NUM_J_CHUNKS - 1))) begin
                     state_q <= S_DRAIN;
                  end
               end
            end
            S_FLUSH: begin
               if (outst_d == '0) begin
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Payload storage carries no reset: contents only matter while counted valid.
   always_ff @(posedge clk) begin
      if (push) begin
         fifo_mem[wr_ptr_q] <= mem_rdata;
      end
   end

endmodule

// File: tb/tb_j_chunk_streamer.sv
// Self-checking bench for j_chunk_streamer: in-order memory model with
// configurable latency, run table, abort/flush and mid-run reset sequences.
module tb_j_chunk_streamer;

   localparam int MEM_BANDWIDTH   = 4096;
   localparam int VECTOR_SIZE     = 256;
   localparam int J_ELEMENT_WIDTH = 4;
   localparam int ADDR_WIDTH      = 16;
   localparam int FIFO_DEPTH      = 4;
   localparam int COLS            = MEM_BANDWIDTH / (VECTOR_SIZE * J_ELEMENT_WIDTH);
   localparam int NCH             = VECTOR_SIZE / COLS;
   localparam int IDX_W           = $clog2(NCH);

   typedef logic [MEM_BANDWIDTH-1:0] word_t;

   typedef struct {
      logic [ADDR_WIDTH-1:0] addr;
      int                    due;
   } resp_t;

   typedef struct {
      logic [ADDR_WIDTH-1:0] base;
      int                    lat;
      int                    stall_pct;
      int                    hold;
      bit                    noise;
      int                    max_cycles;
      logic [ADDR_WIDTH-1:0] exp_first;
      logic [ADDR_WIDTH-1:0] exp_last;
   } run_vec_t;

   // ---------------- clock / reset / DUT ----------------
   logic                     clk = 1'b0;
   logic                     rst_n;
   logic                     start;
   logic                     abort;
   logic [ADDR_WIDTH-1:0]    base_addr;
   logic                     busy;
   logic                     done;
   logic                     mem_req;
   logic [ADDR_WIDTH-1:0]    mem_addr;
   logic                     mem_rvalid;
   logic [MEM_BANDWIDTH-1:0] mem_rdata;
   logic                     chunk_valid;
   logic                     chunk_ready;
   logic [MEM_BANDWIDTH-1:0] chunk_data;
   logic [IDX_W-1:0]         chunk_idx;
   logic                     chunk_last;
   logic [1:0]               dbg_state;

   always #5 clk = ~clk;

   j_chunk_streamer dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .base_addr   (base_addr),
      .busy        (busy),
      .done        (done),
      .mem_req     (mem_req),
      .mem_addr    (mem_addr),
      .mem_rvalid  (mem_rvalid),
      .mem_rdata   (mem_rdata),
      .chunk_valid (chunk_valid),
      .chunk_ready (chunk_ready),
      .chunk_data  (chunk_data),
      .chunk_idx   (chunk_idx),
      .chunk_last  (chunk_last),
      .dbg_state   (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   logic [MEM_BANDWIDTH-1:0] exp_q[$];
   logic [ADDR_WIDTH-1:0]    exp_addr_q[$];
   resp_t                    resp_q[$];

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int lat_cur = 1;
   int hs_count, done_count, req_run, out_model, done_cyc, last_hs_cyc;
   logic [ADDR_WIDTH-1:0] first_addr, last_addr, base_drv;
   logic  ready_drv, abort_drv, start_drv;
   bit    prev_hold;
   word_t prev_data;

   run_vec_t vecs[4];

   // Memory word at address a: element (r,c) = (r + c + a) mod 16.
   function automatic word_t mem_word(input logic [ADDR_WIDTH-1:0] a);
      word_t w = '0;
      for (int r = 0; r < VECTOR_SIZE; r++) begin
         for (int c = 0; c < COLS; c++) begin
            w[(r*COLS+c)*J_ELEMENT_WIDTH +: J_ELEMENT_WIDTH] = J_ELEMENT_WIDTH'((r + c + int'(a)) % 16);
         end
      end
      return w;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic chk_word(input string name, input word_t act, input word_t exp);
      int k;
      k = -1;
      checks++;
      if (act !== exp) begin
         errors++;
         for (int i = 0; i < MEM_BANDWIDTH/32; i++) begin
            if (k < 0 && act[i*32 +: 32] !== exp[i*32 +: 32]) k = i;
         end
         if (k < 0) k = 0;
         $display("FAIL %s: chunk %0d slice %0d got 0x%h expected 0x%h", name, hs_count, k,
                  act[k*32 +: 32], exp[k*32 +: 32]);
      end
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_busy"},        busy,        0);
      chk({tag, "_done"},        done,        0);
      chk({tag, "_mem_req"},     mem_req,     0);
      chk({tag, "_mem_addr"},    mem_addr,    0);
      chk({tag, "_chunk_valid"}, chunk_valid, 0);
      chk({tag, "_chunk_idx"},   chunk_idx,   0);
      chk({tag, "_chunk_last"},  chunk_last,  0);
      chk({tag, "_state"},       dbg_state,   0);
   endtask

   task automatic new_run();
      hs_count    = 0;
      done_count  = 0;
      req_run     = 0;
      done_cyc    = -1;
      last_hs_cyc = -2;
      prev_hold   = 1'b0;
      exp_q.delete();
      exp_addr_q.delete();
   endtask

   task automatic expect_run(input logic [ADDR_WIDTH-1:0] base);
      for (int i = 0; i < NCH; i++) begin
         exp_q.push_back(mem_word(base + ADDR_WIDTH'(i)));
         exp_addr_q.push_back(base + ADDR_WIDTH'(i));
      end
   endtask

   // ---------------- driver: one clock cycle ----------------
   task automatic step();
      @(negedge clk);
      cyc++;
      if (resp_q.size() > 0 && resp_q[0].due <= cyc) begin
         mem_rvalid = 1'b1;
         mem_rdata  = mem_word(resp_q[0].addr);
         void'(resp_q.pop_front());
         if (out_model > 0) out_model--;
      end else begin
         mem_rvalid = 1'b0;
      end
      chunk_ready = ready_drv;
      abort       = abort_drv;
      start       = start_drv;
      base_addr   = base_drv;
      #1;
      if (mem_req) begin
         req_run++;
         if (req_run == 1) first_addr = mem_addr;
         last_addr = mem_addr;
         if (exp_addr_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL mem_req_extra: request to 0x%h with none outstanding in run", mem_addr);
         end else begin
            chk("mem_addr", mem_addr, exp_addr_q.pop_front());
         end
         resp_q.push_back('{addr: mem_addr, due: cyc + lat_cur});
         out_model++;
      end
      if (done) begin
         done_count++;
         done_cyc = cyc;
      end
      if (prev_hold && chunk_valid) chk_word("chunk_data_stable", chunk_data, prev_data);
      if (chunk_valid) begin
         chk("chunk_idx", chunk_idx, hs_count);
         chk("chunk_last", chunk_last, (hs_count == NCH - 1));
      end
      if (chunk_valid && chunk_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL chunk_extra: handshake idx %0d with no chunk expected", chunk_idx);
         end else begin
            chk_word("chunk_data", chunk_data, exp_q.pop_front());
         end
         hs_count++;
         last_hs_cyc = cyc;
      end
      prev_hold = chunk_valid && !chunk_ready;
      prev_data = chunk_data;
   endtask

   // ---------------- table-driven full run ----------------
   task automatic run_vec(input run_vec_t v);
      int cycles;
      new_run();
      lat_cur = v.lat;
      expect_run(v.base);
      base_drv  = v.base;
      start_drv = 1'b1;
      ready_drv = (v.hold == 0);
      step();
      start_drv = 1'b0;
      cycles = 0;
      while (done_count == 0 && cycles < v.max_cycles) begin
         if (cycles < v.hold) ready_drv = 1'b0;
         else if (v.stall_pct > 0) ready_drv = ($urandom_range(0, 99) >= v.stall_pct);
         else ready_drv = 1'b1;
         start_drv = v.noise && (hs_count < NCH - 4) && ($urandom_range(0, 3) == 0);
         step();
         cycles++;
         if (v.hold > 0 && cycles == v.hold) chk("hold_req_count", req_run, FIFO_DEPTH);
      end
      start_drv = 1'b0;
      ready_drv = 1'b1;
      repeat (3) step();
      chk("run_done_count",  done_count, 1);
      chk("run_done_cycle",  done_cyc, last_hs_cyc + 1);
      chk("run_handshakes",  hs_count, NCH);
      chk("run_requests",    req_run, NCH);
      chk("run_first_addr",  first_addr, v.exp_first);
      chk("run_last_addr",   last_addr, v.exp_last);
      chk("run_exp_left",    exp_q.size(), 0);
      chk("run_busy_after",  busy, 0);
   endtask

   // ---------------- main ----------------
   initial begin
      vecs[0] = '{base: 16'h0100, lat: 1, stall_pct: 0,  hold: 0,  noise: 1'b0, max_cycles: 72,
                  exp_first: 16'h0100, exp_last: 16'h013F};
      vecs[1] = '{base: 16'hFFF0, lat: 2, stall_pct: 30, hold: 0,  noise: 1'b1, max_cycles: 1500,
                  exp_first: 16'hFFF0, exp_last: 16'h002F};
      vecs[2] = '{base: 16'h1234, lat: 3, stall_pct: 0,  hold: 20, noise: 1'b0, max_cycles: 110,
                  exp_first: 16'h1234, exp_last: 16'h1273};
      vecs[3] = '{base: 16'h0000, lat: 5, stall_pct: 50, hold: 0,  noise: 1'b1, max_cycles: 2000,
                  exp_first: 16'h0000, exp_last: 16'h003F};

      rst_n = 1'b0;
      start = 1'b0; abort = 1'b0; base_addr = '0;
      mem_rvalid = 1'b0; mem_rdata = '0; chunk_ready = 1'b0;
      start_drv = 1'b0; abort_drv = 1'b0; ready_drv = 1'b0; base_drv = '0;
      out_model = 0;
      new_run();
      repeat (3) @(negedge clk);
      #1;
      chk_reset("por");
      rst_n = 1'b1;

      for (int i = 0; i < 4; i++) run_vec(vecs[i]);

      // Abort at chunk 10 with reads in flight, then flush.
      begin
         int n_req;
         bit flushing;
         new_run();
         lat_cur = 3;
         expect_run(16'h0200);
         base_drv = 16'h0200; start_drv = 1'b1; ready_drv = 1'b1;
         step();
         start_drv = 1'b0;
         for (int i = 0; i < 200 && hs_count < 10; i++) step();
         chk("abort_reach_idx10", hs_count, 10);
         ready_drv = 1'b0; abort_drv = 1'b1;
         n_req = req_run;
         step();
         abort_drv = 1'b0; ready_drv = 1'b1;
         chk("abort_mem_req", req_run, n_req);
         exp_q.delete();
         exp_addr_q.delete();
         flushing = 1'b1;
         for (int i = 0; i < 40 && flushing; i++) begin
            int out_before;
            out_before = out_model;
            step();
            chk("flush_busy", busy, (out_before > 0));
            chk("flush_chunk_valid", chunk_valid, 0);
            if (out_before == 0) flushing = 1'b0;
         end
         chk("flush_ended", flushing, 0);
         chk("flush_done", done_count, 0);
         chk("flush_no_req", req_run, n_req);
         chk("flush_outstanding", out_model, 0);
         chk("flush_handshakes", hs_count, 10);
      end
      run_vec(vecs[0]);

      // Asynchronous reset in the middle of DRAIN.
      new_run();
      lat_cur = 1;
      expect_run(16'h0400);
      base_drv = 16'h0400; start_drv = 1'b1; ready_drv = 1'b1;
      step();
      start_drv = 1'b0;
      for (int i = 0; i < 200 && req_run < NCH; i++) step();
      chk("drain_reqs", req_run, NCH);
      step();
      #2;
      rst_n = 1'b0;
      mem_rvalid = 1'b0;
      #1;
      chk_reset("mid_drain");
      resp_q.delete();
      out_model = 0;
      new_run();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      run_vec(vecs[2]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
